// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
// Size codes, FSM states and the alignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic is_misaligned(
        input size_e      size,
        input logic [1:0] off
    );
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = |off;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store unit.
// Store strobes/replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic        st_misalign,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  size_e       ld_size,
    input  logic        ld_signed,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_result
);

    logic [31:0] shifted;

    assign st_misalign = is_misaligned(st_size, st_off);
    assign shifted     = ld_data >> {ld_off, 3'b000};

    // Store: strobe the addressed lanes, replicate data across the word
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        case (st_size)
            SZ_BYTE: begin
                st_wstrb = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_wstrb = 4'b0011 << st_off;
                st_wdata = {2{st_data[15:0]}};
            end
            SZ_WORD: begin
                st_wstrb = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_wstrb = 4'b0000;
                st_wdata = 32'h0;
            end
        endcase
    end

    // Load: pick the addressed lane and sign- or zero-extend it
    always_comb begin
        ld_result = 32'h0;
        case (ld_size)
            SZ_BYTE: ld_result = {{24{ld_signed & shifted[7]}},
                                  shifted[7:0]};
            SZ_HALF: ld_result = {{16{ld_signed & shifted[15]}},
                                  shifted[15:0]};
            SZ_WORD: ld_result = shifted;
            default: ld_result = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store initiator for the cache CPU port.
// Byte-addressed requests in, word-addressed cache accesses out.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int BITS         = 32,
    parameter int ADDRESS_BITS = 28
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDRESS_BITS+1:0] req_addr,
    input  logic [BITS-1:0]         req_wdata,
    output logic                    resp_valid,
    output logic [BITS-1:0]         resp_rdata,
    output logic                    resp_misalign,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [BITS-1:0]         mem_wdata,
    output logic [3:0]              mem_wstrb,
    output logic                    mem_wr_valid,
    input  logic                    mem_wr_ready,
    output logic                    mem_rd_ready,
    input  logic                    mem_rd_valid,
    input  logic [BITS-1:0]         mem_rdata
);

    if (BITS != 32) begin : g_bits_check
        $error("load_store_unit: only BITS=32 is supported");
    end

    state_e      state;
    size_e       lat_size;
    logic        lat_signed;
    logic [1:0]  lat_off;
    logic        st_misalign;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_result;

    lsu_align u_align (
        .st_size     (size_e'(req_size)),
        .st_off      (req_addr[1:0]),
        .st_data     (req_wdata),
        .st_misalign (st_misalign),
        .st_wstrb    (st_wstrb),
        .st_wdata    (st_wdata),
        .ld_size     (lat_size),
        .ld_signed   (lat_signed),
        .ld_off      (lat_off),
        .ld_data     (mem_rdata),
        .ld_result   (ld_result)
    );

    // Ready only while idle and out of reset
    assign req_ready = (state == IDLE) && !RST;

    // Request FSM; every response and cache-side output is registered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            lat_size      <= SZ_BYTE;
            lat_signed    <= 1'b0;
            lat_off       <= 2'b00;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= 4'b0000;
            mem_wr_valid  <= 1'b0;
            mem_rd_ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_size   <= size_e'(req_size);
                        lat_signed <= req_signed;
                        lat_off    <= req_addr[1:0];
                        if (st_misalign) begin
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                            resp_rdata    <= '0;
                            state         <= RESP;
                        end else if (req_write) begin
                            mem_addr     <= req_addr[ADDRESS_BITS+1:2];
                            mem_wdata    <= st_wdata;
                            mem_wstrb    <= st_wstrb;
                            mem_wr_valid <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            mem_addr     <= req_addr[ADDRESS_BITS+1:2];
                            mem_rd_ready <= 1'b1;
                            state        <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (mem_wr_ready) begin
                        mem_wr_valid <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= '0;
                        state        <= RESP;
                    end
                end
                READ: begin
                    if (mem_rd_valid) begin
                        mem_rd_ready <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= ld_result;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid    <= 1'b0;
                    resp_misalign <= 1'b0;
                    resp_rdata    <= '0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Directed cases plus random requests against a behavioural model.
module tb_load_store_unit;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [27:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic        mem_rd_ready;
    logic        mem_rd_valid;
    logic [31:0] mem_rdata;

    int checks;
    int failures;
    longint unsigned t_accept;

    load_store_unit #(.BITS(32), .ADDRESS_BITS(28)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_ready  (mem_wr_ready),
        .mem_rd_ready  (mem_rd_ready),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rdata     (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Reference rules, written from the request semantics
    function automatic bit ref_misalign(input logic [1:0] sz,
                                        input logic [29:0] a);
        int o;
        o = int'(a % 4);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (o % 2) != 0;
        if (sz == 2'd2) return o != 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [1:0] sz,
                                             input logic [29:0] a);
        int n;
        n = 1 << sz;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz,
                                              input logic [31:0] d);
        if (sz == 2'd0) return {24'h0, d[7:0]} * 32'h01010101;
        if (sz == 2'd1) return {16'h0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                             input bit sg,
                                             input logic [29:0] a,
                                             input logic [31:0] rd);
        int nb;
        longint unsigned v;
        nb = 8 << sz;
        v  = (64'(rd) >> (8 * (a % 4))) & ((64'd1 << nb) - 1);
        if (sg && nb < 32 && v >= (64'd1 << (nb - 1)))
            v = v - (64'd1 << nb);
        return v[31:0];
    endfunction

    // Issue one request at a negedge, act as cache, check it to the end
    task automatic run_req(input bit w, input logic [1:0] sz, input bit sg,
                           input logic [29:0] a, input logic [31:0] d,
                           input int lat, input logic [31:0] rd,
                           input bit hold, output logic [31:0] got);
        bit          mis;
        int          n;
        logic [27:0] c_addr;
        logic [31:0] c_wdata;
        logic [3:0]  c_wstrb;
        mis = ref_misalign(sz, a);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_eq("ready_wait", 32'(req_ready), 32'd1);
        @(posedge CLK);
        t_accept = $time;
        #1;
        if (!hold) req_valid = 1'b0;
        @(negedge CLK);
        check_eq("busy_ready", 32'(req_ready), 32'd0);
        if (mis) begin
            check_eq("mis_valid", 32'(resp_valid), 32'd1);
            check_eq("mis_flag", 32'(resp_misalign), 32'd1);
            check_eq("mis_rdata", resp_rdata, 32'd0);
            check_eq("mis_mem", {30'd0, mem_wr_valid, mem_rd_ready}, 32'd0);
            got = resp_rdata;
        end else begin
            check_eq("early_resp", 32'(resp_valid), 32'd0);
            check_eq("mem_dir", {30'd0, mem_wr_valid, mem_rd_ready},
                     w ? 32'd2 : 32'd1);
            check_eq("mem_addr", 32'(mem_addr), 32'(a[29:2]));
            if (w) begin
                check_eq("wstrb", 32'(mem_wstrb), 32'(ref_wstrb(sz, a)));
                check_eq("wdata", mem_wdata, ref_wdata(sz, d));
            end
            c_addr  = mem_addr;
            c_wdata = mem_wdata;
            c_wstrb = mem_wstrb;
            for (int k = 0; k < lat; k++) begin
                if (w) mem_rd_valid = 1'($urandom % 2);
                else   mem_wr_ready = 1'($urandom % 2);
                mem_rdata = $urandom;
                @(negedge CLK);
                check_eq("wait_dir", {30'd0, mem_wr_valid, mem_rd_ready},
                         w ? 32'd2 : 32'd1);
                check_eq("wait_resp", 32'(resp_valid), 32'd0);
                check_eq("wait_stable",
                         {mem_addr, mem_wstrb} ^ mem_wdata,
                         {c_addr, c_wstrb} ^ c_wdata);
            end
            mem_wr_ready = w;
            mem_rd_valid = !w;
            mem_rdata    = rd;
            @(posedge CLK);
            #1;
            mem_wr_ready = 1'b0;
            mem_rd_valid = 1'b0;
            mem_rdata    = $urandom;
            @(negedge CLK);
            check_eq("resp_valid", 32'(resp_valid), 32'd1);
            check_eq("resp_mis", 32'(resp_misalign), 32'd0);
            check_eq("resp_rdata", resp_rdata,
                     w ? 32'd0 : ref_load(sz, sg, a, rd));
            check_eq("resp_mem", {30'd0, mem_wr_valid, mem_rd_ready}, 32'd0);
            check_eq("resp_ready", 32'(req_ready), 32'd0);
            got = resp_rdata;
        end
        @(negedge CLK);
        check_eq("pulse_end", 32'(resp_valid), 32'd0);
        check_eq("idle_ready", 32'(req_ready), 32'd1);
        check_eq("idle_mem", {30'd0, mem_wr_valid, mem_rd_ready}, 32'd0);
    endtask

    logic [31:0]     got;
    longint unsigned t_prev;

    initial begin
        checks       = 0;
        failures     = 0;
        RST          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_signed   = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_wr_ready = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rdata    = '0;
        repeat (3) @(negedge CLK);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_resp", {29'd0, resp_valid, resp_misalign,
                 |resp_rdata}, 32'd0);
        check_eq("rst_mem", {24'd0, mem_wstrb, 2'd0, mem_wr_valid,
                 mem_rd_ready}, 32'd0);
        check_eq("rst_addr", 32'(mem_addr) | mem_wdata, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("post_rst_ready", 32'(req_ready), 32'd1);

        // 1: word store, immediate ready
        run_req(1, 2'd2, 0, 30'h100, 32'hDEADBEEF, 0, 32'h0, 0, got);
        check_eq("t1_rdata", got, 32'd0);
        // 2: byte store, 3 wait states
        run_req(1, 2'd0, 0, 30'h103, 32'h000000A5, 3, 32'h0, 0, got);
        // 3: loads
        run_req(0, 2'd0, 1, 30'h3, 32'h0, 1, 32'h80FF7F01, 0, got);
        check_eq("t3_sbyte", got, 32'hFFFFFF80);
        run_req(0, 2'd1, 0, 30'h2, 32'h0, 0, 32'h80FF7F01, 0, got);
        check_eq("t3_uhalf", got, 32'h000080FF);
        run_req(0, 2'd1, 1, 30'h0, 32'h0, 2, 32'h80FF7F01, 0, got);
        check_eq("t3_shalf", got, 32'h00007F01);
        // 4: rejected requests
        run_req(0, 2'd1, 0, 30'h101, 32'h0, 0, 32'h0, 0, got);
        run_req(1, 2'd2, 0, 30'h102, 32'h12345678, 0, 32'h0, 0, got);
        run_req(0, 2'd3, 0, 30'h0, 32'h0, 0, 32'h0, 0, got);

        // 5: back-to-back with req_valid held
        run_req(0, 2'd2, 0, 30'h40, 32'h0, 0, 32'h11223344, 1, got);
        t_prev = t_accept;
        run_req(1, 2'd1, 0, 30'h42, 32'hBEEF, 0, 32'h0, 1, got);
        check_eq("b2b_gap1", 32'(t_accept - t_prev), 32'd30);
        t_prev = t_accept;
        run_req(0, 2'd0, 0, 30'h45, 32'h0, 0, 32'hCAFEF00D, 0, got);
        check_eq("b2b_gap2", 32'(t_accept - t_prev), 32'd30);

        // 6: reset while a read waits
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 30'h200;
        req_valid  = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        check_eq("r6_rd_ready", 32'(mem_rd_ready), 32'd1);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check_eq("r6_async_drop", {30'd0, mem_rd_ready, req_ready}, 32'd0);
        mem_rd_valid = 1'b1;
        mem_rdata    = 32'h55555555;
        @(negedge CLK);
        check_eq("r6_no_resp", 32'(resp_valid), 32'd0);
        RST          = 1'b0;
        mem_rd_valid = 1'b0;
        @(negedge CLK);
        check_eq("r6_after", {29'd0, resp_valid, mem_rd_ready, req_ready},
                 32'd1);
        run_req(0, 2'd1, 1, 30'h206, 32'h0, 1, 32'h9ABC1234, 0, got);
        check_eq("r6_fresh", got, 32'hFFFF9ABC);

        // Random traffic, with stray cache responses while idle
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  sz;
            logic [29:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = 30'($urandom);
            if ($urandom % 4 != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom % 8 == 0) begin
                mem_rd_valid = 1'b1;
                mem_wr_ready = 1'b1;
                @(negedge CLK);
                check_eq("idle_stray",
                         {29'd0, resp_valid, mem_wr_valid, mem_rd_ready},
                         32'd0);
                mem_rd_valid = 1'b0;
                mem_wr_ready = 1'b0;
            end
            run_req(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom,
                    $urandom_range(0, 4), $urandom, 0, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
